// File: rtl/var_change_reader.sv
// Change monitor for a single-writer variable: samples var_in each clock and
// queues every detected change as an {old, new, seq} event drained by valid/ready.
module var_change_reader #(
  parameter int               WIDTH = 32,
  parameter int               DEPTH = 4,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [WIDTH-1:0]         var_in,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [WIDTH-1:0]         evt_old,
  output logic [WIDTH-1:0]         evt_new,
  output logic [7:0]               evt_seq,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [15:0]              change_count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [WIDTH-1:0] old_v;
    logic [WIDTH-1:0] new_v;
    logic [7:0]       seq;
  } evt_t;

  evt_t             mem [DEPTH];
  evt_t             hold_q;
  evt_t             head;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    level;
  logic [WIDTH-1:0] last_q;
  logic [7:0]       seq_cnt;
  logic             full, change, push, pop;

  // Case equality so an X/Z on var_in registers as a change in simulation.
  always_comb begin
    full   = (level == LW'(DEPTH));
    pop    = (level != '0) && evt_ready;
    change = en && (var_in !== last_q);
    push   = change && (!full || pop);
  end

  // When empty the outputs keep showing the last head that was popped.
  always_comb begin
    head = hold_q;
    if (level != '0) head = mem[rd_ptr];
  end

  assign evt_valid    = (level != '0);
  assign evt_old      = head.old_v;
  assign evt_new      = head.new_v;
  assign evt_seq      = head.seq;
  assign fifo_level   = level;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      hold_q       <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      last_q       <= INIT;
      seq_cnt      <= '0;
      change_count <= '0;
      overflow     <= 1'b0;
    end else begin
      if (pop) begin
        hold_q <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push) begin
        mem[wr_ptr] <= '{old_v: last_q, new_v: var_in, seq: seq_cnt};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      // Dropped events still advance seq_cnt so consumers can see the gap.
      if (change) begin
        last_q  <= var_in;
        seq_cnt <= seq_cnt + 1'b1;
        if (change_count != 16'hFFFF) change_count <= change_count + 1'b1;
        if (!push) overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_var_change_reader.sv
// Directed bench for var_change_reader: expected events go into a queue,
// a monitor pops and compares them whenever the DUT hands one over.
module tb_var_change_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] var_in;
  logic        evt_valid;
  logic        evt_ready;
  logic [31:0] evt_old;
  logic [31:0] evt_new;
  logic [7:0]  evt_seq;
  logic [2:0]  fifo_level;
  logic [15:0] change_count;
  logic        overflow;

  var_change_reader #(.WIDTH(32), .DEPTH(4), .INIT(32'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .var_in       (var_in),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_old      (evt_old),
    .evt_new      (evt_new),
    .evt_seq      (evt_seq),
    .fifo_level   (fifo_level),
    .change_count (change_count),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] o;
    logic [31:0] n;
    logic [7:0]  s;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic expect_evt(input logic [31:0] o, input logic [31:0] n, input logic [7:0] s);
    exp_t e;
    e.o = o; e.n = n; e.s = s;
    exp_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b1; var_in = 32'h0; evt_ready = 1'b1;

    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          if (!rst && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
              tests++; fails++;
              $display("FAIL evt_unexpected: got old=%0h new=%0h seq=%0d, expected none",
                       evt_old, evt_new, evt_seq);
            end else begin
              e = exp_q.pop_front();
              chk("evt_old", 64'(evt_old), 64'(e.o));
              chk("evt_new", 64'(evt_new), 64'(e.n));
              chk("evt_seq", 64'(evt_seq), 64'(e.s));
            end
          end
        end
      end
    join_none

    // Reset state
    cyc(); cyc();
    chk("rst_valid", 64'(evt_valid), 64'd0);
    chk("rst_old", 64'(evt_old), 64'd0);
    chk("rst_new", 64'(evt_new), 64'd0);
    chk("rst_seq", 64'(evt_seq), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("idle_valid", 64'(evt_valid), 64'd0);
      chk("idle_count", 64'(change_count), 64'd0);
      chk("idle_ovf", 64'(overflow), 64'd0);
    end

    // Toggle 0 -> FFFF_FFFF -> 0
    var_in = 32'hFFFF_FFFF; expect_evt(32'h0, 32'hFFFF_FFFF, 8'd0);
    cyc();
    chk("toggle_lat1", 64'(evt_valid), 64'd1);
    var_in = 32'h0; expect_evt(32'hFFFF_FFFF, 32'h0, 8'd1);
    cyc();
    chk("toggle_lat2", 64'(evt_valid), 64'd1);
    cyc();
    chk("toggle_count", 64'(change_count), 64'd2);
    chk("toggle_level", 64'(fifo_level), 64'd0);

    // Overflow: six changes with no consumer
    do_reset();
    evt_ready = 1'b0;
    for (int v = 1; v <= 6; v++) begin
      var_in = 32'(v);
      if (v <= 4) expect_evt(32'(v - 1), 32'(v), 8'(v - 1));
      cyc();
    end
    chk("ovf_level", 64'(fifo_level), 64'd4);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_count", 64'(change_count), 64'd6);
    evt_ready = 1'b1;
    repeat (4) cyc();
    chk("ovf_drained", 64'(fifo_level), 64'd0);
    var_in = 32'd7; expect_evt(32'd6, 32'd7, 8'd6);
    cyc(); cyc();
    chk("ovf_count7", 64'(change_count), 64'd7);
    chk("ovf_sticky", 64'(overflow), 64'd1);

    // Full FIFO with simultaneous pop and push
    do_reset();
    evt_ready = 1'b0;
    for (int v = 1; v <= 4; v++) begin
      var_in = 32'(v);
      expect_evt(32'(v - 1), 32'(v), 8'(v - 1));
      cyc();
    end
    chk("full_level", 64'(fifo_level), 64'd4);
    evt_ready = 1'b1;
    var_in = 32'd5; expect_evt(32'd4, 32'd5, 8'd4);
    cyc();
    chk("pushpop_level", 64'(fifo_level), 64'd4);
    chk("pushpop_ovf", 64'(overflow), 64'd0);
    repeat (4) cyc();
    chk("pushpop_drained", 64'(fifo_level), 64'd0);

    // Changes while disabled collapse into one event
    do_reset();
    var_in = 32'd5; expect_evt(32'd0, 32'd5, 8'd0);
    cyc();
    en = 1'b0; var_in = 32'd7;
    cyc();
    var_in = 32'd9;
    cyc();
    chk("dis_valid", 64'(evt_valid), 64'd0);
    chk("dis_count", 64'(change_count), 64'd1);
    en = 1'b1; expect_evt(32'd5, 32'd9, 8'd1);
    cyc();
    chk("en_valid", 64'(evt_valid), 64'd1);
    cyc();
    chk("en_count", 64'(change_count), 64'd2);

    // Async reset with three events queued
    do_reset();
    evt_ready = 1'b0;
    for (int v = 1; v <= 3; v++) begin
      var_in = 32'(v);
      cyc();
    end
    chk("pre_arst_level", 64'(fifo_level), 64'd3);
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(evt_valid), 64'd0);
    chk("arst_level", 64'(fifo_level), 64'd0);
    #1 rst = 1'b0;
    evt_ready = 1'b1;
    expect_evt(32'd0, 32'd3, 8'd0);
    cyc(); cyc();
    chk("arst_count", 64'(change_count), 64'd1);
    chk("arst_level2", 64'(fifo_level), 64'd0);

    cyc();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/var_change_reader.md
Name: var_change_reader

Overview:
- Reader side of a single-writer integer variable: samples a WIDTH-bit variable each clock and detects value changes.
- Each change is queued as an {old, new, seq} event in a small FIFO and drained through a valid/ready handshake.
- Sits in elaboration/simulation test benches as the monitor of a variable owned by exactly one procedural writer, e.g. an always block toggling v <= ~v.
- Gives self-checking tests a cycle-accurate change log.

Parameters:
- WIDTH, 32, bit width of the observed variable (int-sized by default).
- DEPTH, 4, event FIFO depth; power of two, minimum 2.
- INIT, 0, reset value of the shadow register, i.e. the value assumed before the first sample.

Ports:
- clk  input  1  single clock; all state updates on posedge clk.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  sampling enable; 0 freezes change detection.
- var_in  input  WIDTH  observed variable value.
- evt_valid  output  1  head event available.
- evt_ready  input  1  consumer accepts head event.
- evt_old  output  WIDTH  value before the change.
- evt_new  output  WIDTH  value after the change.
- evt_seq  output  8  change sequence number of the head event.
- fifo_level  output  $clog2(DEPTH)+1  number of queued events.
- change_count  output  16  total detected changes, saturating.
- overflow  output  1  sticky: at least one event dropped.

Behaviour:
- Reset (asynchronous assert, synchronous-to-clk deassert handled externally):
  - shadow register last_q = INIT; FIFO emptied.
  - evt_valid = 0, evt_old = 0, evt_new = 0, evt_seq = 0.
  - fifo_level = 0, change_count = 0, overflow = 0, internal seq counter = 0.
- Reset mid-operation discards all queued events immediately, without waiting for a clock edge.
- Detection, at each posedge with en = 1:
  - change = (var_in != last_q); full-width compare, X/Z in var_in counts as a change in simulation.
  - On change:
    - push {old = last_q, new = var_in, seq = seq_cnt}.
    - last_q <= var_in.
    - seq_cnt <= seq_cnt + 1, wrapping modulo 256.
    - change_count increments, saturating at 16'hFFFF.
- en = 0: no compare, no push; last_q, seq_cnt and change_count hold.
  - A value change while disabled is reported on the first enabled cycle as a single event, with old = the last value seen while enabled.
- FIFO pop: occurs when evt_valid && evt_ready at posedge. evt_* are driven combinationally from the head entry; evt_valid = (fifo_level != 0).
- Latency: a change present on var_in before posedge N gives evt_valid = 1 after posedge N, i.e. visible in cycle N+1 when the FIFO was empty.
- Simultaneous push and pop:
  - Allowed at any level, including full; fifo_level unchanged.
  - When full, the pop frees the slot, so no drop occurs.
- Full with no pop and a change:
  - The event is dropped and overflow <= 1, sticky until reset.
  - last_q, seq_cnt and change_count still update, so the seq gap identifies lost events.
- Empty with evt_ready = 1: no effect; evt_* hold their last head values.
- Head payload remains stable while evt_valid = 1 && evt_ready = 0 (AXI-style hold rule).
- Pointers wrap modulo DEPTH; fifo_level ranges 0..DEPTH.
- Only this block writes its state, all from one clocked process plus the async reset. It never drives var_in, keeping the observed variable single-driver.

Test Plan:
- Reset with var_in = 0, en = 1, evt_ready = 1 held 10 cycles:
  - evt_valid = 0, change_count = 0, overflow = 0 throughout.
- Writer toggles var_in 0 -> 32'hFFFF_FFFF -> 0 on successive cycles, evt_ready = 1:
  - events {0, FFFF_FFFF, seq 0} and {FFFF_FFFF, 0, seq 1}, each one cycle after its change.
  - change_count = 2.
- evt_ready = 0, six distinct values on var_in (DEPTH = 4):
  - fifo_level saturates at 4, overflow = 1.
  - change_count = 6; queued seq values 0..3.
  - Next change after draining gets seq 6.
- FIFO full, evt_ready = 1, and a change in the same cycle:
  - no drop, fifo_level stays 4, overflow stays 0.
- en = 0 while var_in goes 5 -> 7 -> 9, then en = 1:
  - exactly one event {old = 5, new = 9}.
- Async reset asserted mid-cycle with 3 events queued:
  - evt_valid = 0 and fifo_level = 0 before the next clock edge.
  - seq restarts at 0 after release.
